// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: decode inputs and control-word outputs of the CPU control sequencer.
// The sequencer sits on the master side: it reads opcode/flags and drives controls.
interface ctrl_seq_if #(
    parameter int OP_W = 4
);
    // Decode inputs (IR upper nibble and registered ALU flags)
    logic [OP_W-1:0] opcode;
    logic            carry_flag;
    logic            zero_flag;

    // Bus drivers
    logic            pc_rd_en;
    logic            ir_rd_en;
    logic            ram_rd_en;
    logic            a_rd_en;
    logic            alu_rd_en;

    // Bus loads
    logic            mar_wr_en;
    logic            ir_wr_en;
    logic            a_wr_en;
    logic            b_wr_en;
    logic            ram_wr_en;
    logic            out_wr_en;
    logic            pc_wr_en;
    logic            flags_wr_en;

    // Miscellaneous controls and status
    logic            pc_inc;
    logic            alu_sub;
    logic            halt;
    logic [2:0]      t_state;

    modport master (
        input  opcode, carry_flag, zero_flag,
        output pc_rd_en, ir_rd_en, ram_rd_en, a_rd_en, alu_rd_en,
        output mar_wr_en, ir_wr_en, a_wr_en, b_wr_en, ram_wr_en, out_wr_en,
        output pc_wr_en, flags_wr_en, pc_inc, alu_sub, halt, t_state
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  pc_rd_en, ir_rd_en, ram_rd_en, a_rd_en, alu_rd_en,
        input  mar_wr_en, ir_wr_en, a_wr_en, b_wr_en, ram_wr_en, out_wr_en,
        input  pc_wr_en, flags_wr_en, pc_inc, alu_sub, halt, t_state
    );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: five-state T-cycle control sequencer for the 8-bit bus CPU.
// T0/T1 fetch, T2..T4 execute; HLT parks the sequencer in HALT until clr.
// The control word is combinational from (t_state, opcode, flags) and is
// forced to zero while clr is high, run is low, or the sequencer is halted.
// Build option: define CTRL_JUMP_EN to decode JMP/JC/JZ and drive pc_wr_en;
// without it opcodes 0x6..0x8 act as NOP and pc_wr_en is tied low.
module ctrl_seq #(
    parameter int OP_W   = 4,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    ctrl_seq_if.master bus
);

    // Opcode and operand are expected to fill the 8-bit instruction register;
    // the operand itself never reaches the sequencer.
    localparam int IR_W = OP_W + ADDR_W;
    if (IR_W != 8) begin : g_nonstd_ir_width
    end

    localparam logic [OP_W-1:0] OPC_LDA = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OPC_ADD = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OPC_SUB = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OPC_STA = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OPC_LDI = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OPC_OUT = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OPC_HLT = OP_W'(4'hF);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } tstate_e;

    tstate_e state_q;
    tstate_e state_d;

    logic active;
    logic mem_op;
    logic alu_op;

    logic pc_rd, ir_rd, ram_rd, a_rd, alu_rd;
    logic mar_wr, ir_wr, a_wr, b_wr, ram_wr, out_wr, flags_wr;
    logic pc_inc, alu_sub;

    assign active = !clr && run && (state_q != HALT);
    assign mem_op = (bus.opcode == OPC_LDA) || (bus.opcode == OPC_ADD) ||
                    (bus.opcode == OPC_SUB) || (bus.opcode == OPC_STA);
    assign alu_op = (bus.opcode == OPC_ADD) || (bus.opcode == OPC_SUB);

`ifdef CTRL_JUMP_EN
    localparam logic [OP_W-1:0] OPC_JMP = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OPC_JC  = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OPC_JZ  = OP_W'(4'h8);

    logic pc_wr;
    logic jump_taken;

    // Flags are looked at only in T2, combinationally, so a flag update from
    // the previous instruction's T4 is already visible.
    assign jump_taken = (bus.opcode == OPC_JMP) ||
                        ((bus.opcode == OPC_JC) && bus.carry_flag) ||
                        ((bus.opcode == OPC_JZ) && bus.zero_flag);
`endif

    // Next T-state: clr dominates, HALT is sticky, run=0 freezes in place.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = T0;
        end else if ((state_q != HALT) && run) begin
            case (state_q)
                T0:      state_d = T1;
                T1:      state_d = T2;
                T2:      state_d = (bus.opcode == OPC_HLT) ? HALT : T3;
                T3:      state_d = T4;
                T4:      state_d = T0;
                default: state_d = T0;
            endcase
        end
    end

    // T-state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Control-word decode; each branch raises at most one bus driver.
    always_comb begin
        pc_rd    = 1'b0;
        ir_rd    = 1'b0;
        ram_rd   = 1'b0;
        a_rd     = 1'b0;
        alu_rd   = 1'b0;
        mar_wr   = 1'b0;
        ir_wr    = 1'b0;
        a_wr     = 1'b0;
        b_wr     = 1'b0;
        ram_wr   = 1'b0;
        out_wr   = 1'b0;
        flags_wr = 1'b0;
        pc_inc   = 1'b0;
        alu_sub  = 1'b0;
`ifdef CTRL_JUMP_EN
        pc_wr    = 1'b0;
`endif
        if (active) begin
            case (state_q)
                T0: begin
                    pc_rd  = 1'b1;
                    mar_wr = 1'b1;
                end
                T1: begin
                    ram_rd = 1'b1;
                    ir_wr  = 1'b1;
                    pc_inc = 1'b1;
                end
                T2: begin
                    if (mem_op) begin
                        ir_rd  = 1'b1;
                        mar_wr = 1'b1;
                    end else if (bus.opcode == OPC_LDI) begin
                        ir_rd = 1'b1;
                        a_wr  = 1'b1;
                    end else if (bus.opcode == OPC_OUT) begin
                        a_rd   = 1'b1;
                        out_wr = 1'b1;
                    end
`ifdef CTRL_JUMP_EN
                    else if (jump_taken) begin
                        ir_rd = 1'b1;
                        pc_wr = 1'b1;
                    end
`endif
                end
                T3: begin
                    if (bus.opcode == OPC_LDA) begin
                        ram_rd = 1'b1;
                        a_wr   = 1'b1;
                    end else if (alu_op) begin
                        ram_rd = 1'b1;
                        b_wr   = 1'b1;
                    end else if (bus.opcode == OPC_STA) begin
                        a_rd   = 1'b1;
                        ram_wr = 1'b1;
                    end
                end
                T4: begin
                    if (alu_op) begin
                        alu_rd   = 1'b1;
                        a_wr     = 1'b1;
                        flags_wr = 1'b1;
                        alu_sub  = (bus.opcode == OPC_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc_rd_en    = pc_rd;
    assign bus.ir_rd_en    = ir_rd;
    assign bus.ram_rd_en   = ram_rd;
    assign bus.a_rd_en     = a_rd;
    assign bus.alu_rd_en   = alu_rd;
    assign bus.mar_wr_en   = mar_wr;
    assign bus.ir_wr_en    = ir_wr;
    assign bus.a_wr_en     = a_wr;
    assign bus.b_wr_en     = b_wr;
    assign bus.ram_wr_en   = ram_wr;
    assign bus.out_wr_en   = out_wr;
    assign bus.flags_wr_en = flags_wr;
    assign bus.pc_inc      = pc_inc;
    assign bus.alu_sub     = alu_sub;
    assign bus.halt        = (state_q == HALT);
    assign bus.t_state     = state_q;

`ifdef CTRL_JUMP_EN
    assign bus.pc_wr_en    = pc_wr;
`else
    // Jumps compiled out: flags have no consumer and the PC is never loaded.
    logic unused_flags;
    assign unused_flags    = bus.carry_flag ^ bus.zero_flag;
    assign bus.pc_wr_en    = 1'b0;
`endif

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Microcoded control sequencer for the 8-bit bus-based CPU. It steps a fixed five-state T-cycle (two fetch states, three execute states) and decodes the instruction-register opcode and ALU flags. From these it generates every register's write/read enable and the PC, RAM, ALU and output controls. It guarantees at most one bus driver per cycle, stops on HLT, and supports freezing via `run`.

## Interface
Parameters:
- `OP_W`, 4, opcode width (upper nibble of IR).
- `ADDR_W`, 4, operand width (lower nibble of IR).

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `clr`  input  1  synchronous, active-high reset.
- `run`  input  1  1 = advance T-state each cycle; 0 = freeze.
- `opcode`  input  OP_W  IR upper nibble; valid from T2 onward.
- `carry_flag`, `zero_flag`  input  1 each  registered ALU flags.
- `pc_rd_en`, `ir_rd_en`, `ram_rd_en`, `a_rd_en`, `alu_rd_en`  output  1 each  bus drivers.
- `mar_wr_en`, `ir_wr_en`, `a_wr_en`, `b_wr_en`, `ram_wr_en`, `out_wr_en`, `pc_wr_en`, `flags_wr_en`  output  1 each  bus loads.
- `pc_inc`, `alu_sub`  output  1 each  PC increment; ALU subtract select.
- `halt`  output  1  high while halted.
- `t_state`  output  3  current state: 0–4; 7 = HALT.

## Operation
- State register: T0→T1→T2→T3→T4→T0. Every instruction takes exactly 5 cycles; unused execute states emit no controls.
- The control word is a combinational function of (`t_state`, `opcode`, flags), gated to all-zero when `clr`=1, `run`=0 or `t_state`=HALT.
- Fetch:
  - T0: `pc_rd_en`, `mar_wr_en`.
  - T1: `ram_rd_en`, `ir_wr_en`, `pc_inc`.
- Execute (T2/T3/T4):
  - NOP 0x0: none.
  - LDA 0x1: T2 `ir_rd_en`+`mar_wr_en`; T3 `ram_rd_en`+`a_wr_en`.
  - ADD 0x2: T2 as LDA; T3 `ram_rd_en`+`b_wr_en`; T4 `alu_rd_en`+`a_wr_en`+`flags_wr_en`.
  - SUB 0x3: as ADD, plus `alu_sub` in T4.
  - STA 0x4: T2 as LDA; T3 `a_rd_en`+`ram_wr_en`.
  - LDI 0x5: T2 `ir_rd_en`+`a_wr_en`.
  - JMP 0x6 / JC 0x7 / JZ 0x8: T2 `ir_rd_en`+`pc_wr_en`. JC requires `carry_flag`=1 and JZ requires `zero_flag`=1; otherwise no controls.
  - OUT 0xE: T2 `a_rd_en`+`out_wr_en`.
  - HLT 0xF: at T2, the next state is HALT.
  - 0x9–0xD: NOP.
- Invariant: at most one `*_rd_en` is high in any cycle.
- HALT: `halt`=1 and all controls 0. Only `clr` exits HALT.

## Timing
- Reset: `clr` sampled high at a rising edge sets `t_state`=0 and `halt`=0. While `clr` is high, every control output is 0.
- First fetch: controls appear in the first cycle after `clr` falls.
- `run`=0: state holds and controls are 0. When `run` returns to 1, the same T-state re-emits its controls. Freezing mid-instruction is therefore lossless.
- `clr` mid-instruction: abandons the instruction; the next state is T0 with no partial completion.
- `clr` and `run`=0 together: `clr` wins.
- Flags are sampled combinationally during T2 of JC/JZ.
- `halt` rises in the cycle following the HLT T2 edge.

## Configuration
- `CTRL_JUMP_EN` defined: JMP/JC/JZ are decoded as above and `pc_wr_en` is functional.
- `CTRL_JUMP_EN` undefined: opcodes 0x6–0x8 decode as NOP and `pc_wr_en` is tied to 0.

## Test plan
- Reset: hold `clr` for 2 cycles with `run`=1 → all outputs 0 and `t_state`=0. On the first cycle after release, `pc_rd_en`=`mar_wr_en`=1.
- ADD: `opcode`=0x2 with flags 0 → T2 `ir_rd_en`,`mar_wr_en`; T3 `ram_rd_en`,`b_wr_en`; T4 `alu_rd_en`,`a_wr_en`,`flags_wr_en`, `alu_sub`=0; next cycle `t_state`=0.
- Conditional jump: JC with `carry_flag`=1 → `pc_wr_en`=1 in T2. JC with `carry_flag`=0 → `pc_wr_en`=0 throughout. JZ with `zero_flag`=1 → `pc_wr_en`=1.
- Freeze: drop `run` at T3 of LDA for 3 cycles → `t_state` stays 3 and controls are 0. On resume, `ram_rd_en`+`a_wr_en` assert exactly once.
- Halt and recovery: HLT → `halt`=1 and `t_state`=7 indefinitely with controls 0. A `clr` pulse then gives `t_state`=0 and `halt`=0.
- Macro off: build without `CTRL_JUMP_EN` and issue JMP 0x6 → no `pc_wr_en` across all 5 states.
- All runs: assertion that no two `*_rd_en` are high in the same cycle.
